// File: rtl/sub_chunk_pkg.sv
// Shared types and constants for the sub-chunk engine: sizing parameters,
// derived field widths, FSM state encoding, error codes and address helpers.
package sub_chunk_pkg;

   localparam int RD_CYC_NUM      = 8;
   localparam int PREFIX_SUM_SIZE = 32;
   localparam int OUTPUT_BUF_NUM  = 64;
   localparam int FIL_NZ_DEPTH    = 32;
   localparam int CNT_W           = 16;

   localparam int RD_ADDR_W = $clog2(RD_CYC_NUM);
   localparam int SHIFT_W   = $clog2(PREFIX_SUM_SIZE);
   localparam int BUF_SEL_W = $clog2(OUTPUT_BUF_NUM);
   localparam int FIL_NZ_W  = $clog2(FIL_NZ_DEPTH);
   localparam int BEAT_W    = $clog2(RD_CYC_NUM + 1);
   localparam int POP_W     = $clog2(PREFIX_SUM_SIZE + 1);

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_OVERRUN = 2'd1;
   localparam logic [1:0] ERR_WINDOW  = 2'd2;

   typedef enum logic [2:0] {
      IDLE,
      PRIME,
      FETCH,
      FLUSH,
      DONE
   } state_t;

   // Sparsemap addresses wrap from the last word back to word 0.
   function automatic logic [RD_ADDR_W-1:0] addr_inc(input logic [RD_ADDR_W-1:0] a);
      if (a == RD_ADDR_W'(RD_CYC_NUM - 1)) begin
         return '0;
      end
      return a + 1'b1;
   endfunction

   // Number of words in an inclusive window; last < first means it wrapped.
   function automatic logic [BEAT_W-1:0] beat_count(input logic [RD_ADDR_W-1:0] first,
                                                    input logic [RD_ADDR_W-1:0] last);
      logic [BEAT_W-1:0] f;
      logic [BEAT_W-1:0] l;
      f = BEAT_W'(first);
      l = BEAT_W'(last);
      if (l >= f) begin
         return l - f + 1'b1;
      end
      return l + BEAT_W'(RD_CYC_NUM) - f + 1'b1;
   endfunction

endpackage

// File: rtl/sub_chunk_popcount.sv
// Combinational population count of one sparsemap word.
module sub_chunk_popcount
   import sub_chunk_pkg::*;
#(
   parameter int W  = PREFIX_SUM_SIZE,
   parameter int CW = $clog2(PREFIX_SUM_SIZE + 1)
)
(
   input  logic [W-1:0]  vec,
   output logic [CW-1:0] count
);

   // Sum every set bit of the input word.
   always_comb begin
      count = '0;
      for (int i = 0; i < W; i++) begin
         count = count + CW'(vec[i]);
      end
   end

endmodule

// File: rtl/sub_chunk_engine.sv
// Responder for one inner-loop sub-chunk: streams filter and IFM sparsemap
// words, aligns IFM words by the commanded bit shift, counts positions that
// are non-zero in both, then pulses end together with an accumulator write.
// Optional error checking is built when SUB_CHUNK_ERR_CHK_EN is defined.
module sub_chunk_engine
   import sub_chunk_pkg::*;
(
   input  logic                       clk_i,
   input  logic                       rst_n_i,
   input  logic                       sub_chunk_start_i,
   input  logic [RD_ADDR_W-1:0]       rd_fil_sparsemap_first_i,
   input  logic [RD_ADDR_W-1:0]       rd_fil_sparsemap_last_i,
   input  logic [FIL_NZ_W-1:0]        rd_fil_nonzero_dat_first_i,
   input  logic [RD_ADDR_W-1:0]       rd_ifm_sparsemap_first_i,
   input  logic [SHIFT_W-1:0]         sparsemap_shift_left_i,
   input  logic [RD_ADDR_W-1:0]       rd_ifm_sparsemap_next_i,
   input  logic [BUF_SEL_W-1:0]       acc_buf_sel_i,
   output logic                       fil_rd_en_o,
   output logic [RD_ADDR_W-1:0]       fil_rd_addr_o,
   input  logic [PREFIX_SUM_SIZE-1:0] fil_dat_i,
   output logic                       ifm_rd_en_o,
   output logic [RD_ADDR_W-1:0]       ifm_rd_addr_o,
   input  logic [PREFIX_SUM_SIZE-1:0] ifm_dat_i,
   output logic                       acc_wr_en_o,
   output logic [BUF_SEL_W-1:0]       acc_buf_sel_o,
   output logic [FIL_NZ_W-1:0]        fil_nz_base_o,
   output logic [CNT_W-1:0]           match_cnt_o,
   output logic                       sub_chunk_end_o,
   output logic                       busy_o
`ifdef SUB_CHUNK_ERR_CHK_EN
   ,
   output logic                       err_o,
   output logic [1:0]                 err_code_o
`endif
);

   state_t                     state;
   logic [BEAT_W-1:0]          beats_left;
   logic [SHIFT_W-1:0]         shift_q;
   logic [RD_ADDR_W-1:0]       ifm_next_q;
   logic                       fil_vld;
   logic                       ifm_vld;
   logic [PREFIX_SUM_SIZE-1:0] ifm_prev;
   logic [PREFIX_SUM_SIZE-1:0] aligned;
   logic [SHIFT_W:0]           rshift;
   logic [POP_W-1:0]           pop;
   logic [CNT_W:0]             cnt_sum;
   logic                       accept;
   logic [BEAT_W-1:0]          cmd_beats;

   assign accept    = sub_chunk_start_i && ((state == IDLE) || (state == DONE));
   assign cmd_beats = beat_count(rd_fil_sparsemap_first_i, rd_fil_sparsemap_last_i);

   // Sequence the command: latch fields, drive both read ports, signal completion.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state           <= IDLE;
         beats_left      <= '0;
         shift_q         <= '0;
         ifm_next_q      <= '0;
         acc_buf_sel_o   <= '0;
         fil_nz_base_o   <= '0;
         fil_rd_en_o     <= 1'b0;
         fil_rd_addr_o   <= '0;
         ifm_rd_en_o     <= 1'b0;
         ifm_rd_addr_o   <= '0;
         sub_chunk_end_o <= 1'b0;
         acc_wr_en_o     <= 1'b0;
         busy_o          <= 1'b0;
      end else begin
         sub_chunk_end_o <= 1'b0;
         acc_wr_en_o     <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (accept) begin
                  acc_buf_sel_o <= acc_buf_sel_i;
                  fil_nz_base_o <= rd_fil_nonzero_dat_first_i;
                  shift_q       <= sparsemap_shift_left_i;
                  ifm_next_q    <= rd_ifm_sparsemap_next_i;
                  beats_left    <= cmd_beats;
                  fil_rd_addr_o <= rd_fil_sparsemap_first_i;
                  ifm_rd_en_o   <= 1'b1;
                  ifm_rd_addr_o <= rd_ifm_sparsemap_first_i;
                  busy_o        <= 1'b1;
                  if (sparsemap_shift_left_i != '0) begin
                     state       <= PRIME;
                     fil_rd_en_o <= 1'b0;
                  end else begin
                     state       <= FETCH;
                     fil_rd_en_o <= 1'b1;
                  end
               end else begin
                  state       <= IDLE;
                  busy_o      <= 1'b0;
                  fil_rd_en_o <= 1'b0;
                  ifm_rd_en_o <= 1'b0;
               end
            end
            PRIME: begin
               state         <= FETCH;
               fil_rd_en_o   <= 1'b1;
               ifm_rd_en_o   <= 1'b1;
               ifm_rd_addr_o <= addr_inc(ifm_rd_addr_o);
            end
            FETCH: begin
               if (beats_left <= BEAT_W'(1)) begin
                  state         <= FLUSH;
                  fil_rd_en_o   <= 1'b0;
                  ifm_rd_en_o   <= 1'b1;
                  ifm_rd_addr_o <= ifm_next_q;
               end else begin
                  beats_left    <= beats_left - 1'b1;
                  fil_rd_addr_o <= addr_inc(fil_rd_addr_o);
                  ifm_rd_addr_o <= addr_inc(ifm_rd_addr_o);
               end
            end
            FLUSH: begin
               state           <= DONE;
               ifm_rd_en_o     <= 1'b0;
               sub_chunk_end_o <= 1'b1;
               acc_wr_en_o     <= 1'b1;
            end
            default: begin
               state       <= IDLE;
               busy_o      <= 1'b0;
               fil_rd_en_o <= 1'b0;
               ifm_rd_en_o <= 1'b0;
            end
         endcase
      end
   end

   // Track which cycles carry returned read data and keep the previous IFM word.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         fil_vld  <= 1'b0;
         ifm_vld  <= 1'b0;
         ifm_prev <= '0;
      end else begin
         fil_vld <= fil_rd_en_o;
         ifm_vld <= ifm_rd_en_o;
         if (ifm_vld) begin
            ifm_prev <= ifm_dat_i;
         end
      end
   end

   // Splice the older IFM word above the current one and take the top word.
   always_comb begin
      rshift = (SHIFT_W + 1)'(PREFIX_SUM_SIZE) - {1'b0, shift_q};
      if (shift_q != '0) begin
         aligned = (ifm_prev << shift_q) | (ifm_dat_i >> rshift);
      end else begin
         aligned = ifm_dat_i;
      end
   end

   sub_chunk_popcount #(
      .W  (PREFIX_SUM_SIZE),
      .CW (POP_W)
   ) u_popcount (
      .vec   (aligned & fil_dat_i),
      .count (pop)
   );

   assign cnt_sum = {1'b0, match_cnt_o} + {{(CNT_W + 1 - POP_W){1'b0}}, pop};

   // Clear on a new command, then add each beat's matches, saturating.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         match_cnt_o <= '0;
      end else if (accept) begin
         match_cnt_o <= '0;
      end else if (fil_vld) begin
         match_cnt_o <= cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
      end
   end

`ifdef SUB_CHUNK_ERR_CHK_EN
   logic overrun;
   logic window_bad;

   assign overrun    = sub_chunk_start_i &&
                       ((state == PRIME) || (state == FETCH) || (state == FLUSH));
   assign window_bad = accept &&
                       (rd_fil_sparsemap_first_i == addr_inc(rd_fil_sparsemap_last_i));

   // Record the first protocol error and hold it until reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         err_o      <= 1'b0;
         err_code_o <= ERR_NONE;
      end else if (!err_o) begin
         if (overrun) begin
            err_o      <= 1'b1;
            err_code_o <= ERR_OVERRUN;
         end else if (window_bad) begin
            err_o      <= 1'b1;
            err_code_o <= ERR_WINDOW;
         end
      end
   end
`endif

endmodule
